// File: rtl/gpio_cfg_loader_pkg.sv
// Shared constants and state encoding for the mprj_io pad configuration loader.
// Pad count, per-pad word width and the loader FSM states.
package gpio_cfg_loader_pkg;

    localparam int unsigned MPRJ_IO_PADS  = 38;
    localparam int unsigned GPIO_CFG_BITS = 13;

    localparam logic [2:0] STATE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_FETCH = 3'd1;
    localparam logic [2:0] STATE_SHIFT = 3'd2;
    localparam logic [2:0] STATE_LOAD  = 3'd3;
    localparam logic [2:0] STATE_DONE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = STATE_IDLE,
        StFetch = STATE_FETCH,
        StShift = STATE_SHIFT,
        StLoad  = STATE_LOAD,
        StDone  = STATE_DONE
    } loader_state_e;

endpackage

// File: rtl/gpio_cfg_shifter.sv
// Serialises one pad configuration word MSB first with a divided serial_clock.
// Data changes at the start of each low phase; word_done marks the end of bit 0's high phase.
module gpio_cfg_shifter
    import gpio_cfg_loader_pkg::*;
#(
    parameter int unsigned CFG_BITS = GPIO_CFG_BITS,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                clear,
    input  logic                load_word,
    input  logic                shift_en,
    input  logic [CFG_BITS-1:0] word,
    output logic                word_done,
    output logic                serial_clock,
    output logic                serial_data_out
);

    localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int unsigned DW = $clog2(CLK_DIV + 1);

    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic                sclk_q, sclk_d;
    logic                sdo_q, sdo_d;
    logic                div_wrap;
    logic                last_bit;

    assign div_wrap  = (div_cnt_q == DW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt_q == '0);
    assign word_done = shift_en & sclk_q & div_wrap & last_bit;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        if (clear) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            sdo_d     = 1'b0;
        end else if (load_word) begin
            shreg_d   = word;
            bit_cnt_d = BW'(CFG_BITS - 1);
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            sdo_d     = word[CFG_BITS-1];
        end else if (shift_en) begin
            if (div_wrap) begin
                div_cnt_d = '0;
                sclk_d    = ~sclk_q;
                // Falling edge: present the next bit; after bit 0 the line just holds.
                if (sclk_q && !last_bit) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    sdo_d     = shreg_q[CFG_BITS-2];
                end
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
        end
    end

    assign serial_clock    = sclk_q;
    assign serial_data_out = sdo_q;

endmodule

// File: rtl/gpio_cfg_loader.sv
// Walks the pad configuration words from pad NUM_PADS-1 down to pad 0 into the
// mprj_io serial chain, then strobes serial_load so all pads switch together.
module gpio_cfg_loader
    import gpio_cfg_loader_pkg::*;
#(
    parameter int unsigned NUM_PADS = MPRJ_IO_PADS,
    parameter int unsigned CFG_BITS = GPIO_CFG_BITS,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_PADS)-1:0] cfg_rd_addr,
    input  logic [CFG_BITS-1:0]         cfg_rd_data,
    output logic                        serial_clock,
    output logic                        serial_data_out,
    output logic                        serial_load
);

    localparam int unsigned AW = $clog2(NUM_PADS);
    localparam int unsigned LW = $clog2(CLK_DIV + 1);

    loader_state_e state_q, state_d;
    logic          fetch_ph_q, fetch_ph_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, done_q, load_q;
    logic          busy_d, done_d, load_d;
    logic          load_word, shift_en, clear, word_done;

    always_comb begin
        state_d    = state_q;
        fetch_ph_d = fetch_ph_q;
        load_cnt_d = load_cnt_q;
        addr_d     = addr_q;
        load_word  = 1'b0;
        shift_en   = 1'b0;
        clear      = 1'b0;
        if (abort && state_q != StIdle) begin
            state_d    = StIdle;
            fetch_ph_d = 1'b0;
            load_cnt_d = '0;
            clear      = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_d    = StFetch;
                        addr_d     = AW'(NUM_PADS - 1);
                        fetch_ph_d = 1'b0;
                    end
                end
                StFetch: begin
                    // Phase 0 presents the address; read data is valid in phase 1.
                    if (!fetch_ph_q) begin
                        fetch_ph_d = 1'b1;
                    end else begin
                        fetch_ph_d = 1'b0;
                        load_word  = 1'b1;
                        state_d    = StShift;
                    end
                end
                StShift: begin
                    shift_en = 1'b1;
                    if (word_done) begin
                        if (addr_q != '0) begin
                            addr_d  = addr_q - AW'(1);
                            state_d = StFetch;
                        end else begin
                            load_cnt_d = '0;
                            state_d    = StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (load_cnt_q == LW'(CLK_DIV - 1)) begin
                        load_cnt_d = '0;
                        state_d    = StDone;
                    end else begin
                        load_cnt_d = load_cnt_q + LW'(1);
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy_d = (state_d == StFetch) || (state_d == StShift) || (state_d == StLoad);
    assign done_d = (state_d == StDone);
    assign load_d = (state_d == StLoad);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            fetch_ph_q <= 1'b0;
            load_cnt_q <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_ph_q <= fetch_ph_d;
            load_cnt_q <= load_cnt_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            load_q     <= load_d;
        end
    end

    gpio_cfg_shifter #(
        .CFG_BITS (CFG_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_shifter (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .clear           (clear),
        .load_word       (load_word),
        .shift_en        (shift_en),
        .word            (cfg_rd_data),
        .word_done       (word_done),
        .serial_clock    (serial_clock),
        .serial_data_out (serial_data_out)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign serial_load = load_q;
    assign cfg_rd_addr = addr_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Directed bench for gpio_cfg_loader: three instances cover CLK_DIV=1, CLK_DIV=3
// and the full 38-pad chain checked against a shift-chain model.
module tb_gpio_cfg_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A: 3 pads, 4 bits, CLK_DIV=1
    logic       start_a = 0, abort_a = 0, busy_a, done_a, sclk_a, sdo_a, load_a;
    logic [1:0] addr_a;
    logic [3:0] rd_a = '0;
    logic [3:0] mem_a [4];
    // Instance B: 3 pads, 4 bits, CLK_DIV=3
    logic       start_b = 0, abort_b = 0, busy_b, done_b, sclk_b, sdo_b, load_b;
    logic [1:0] addr_b;
    logic [3:0] rd_b = '0;
    // Instance C: 38 pads, 13 bits, CLK_DIV=2
    logic        start_c = 0, abort_c = 0, busy_c, done_c, sclk_c, sdo_c, load_c;
    logic [5:0]  addr_c;
    logic [12:0] rd_c = '0;
    logic [12:0] mem_c [64];

    gpio_cfg_loader #(.NUM_PADS(3), .CFG_BITS(4), .CLK_DIV(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .abort(abort_a), .busy(busy_a),
        .done(done_a), .cfg_rd_addr(addr_a), .cfg_rd_data(rd_a), .serial_clock(sclk_a),
        .serial_data_out(sdo_a), .serial_load(load_a));

    gpio_cfg_loader #(.NUM_PADS(3), .CFG_BITS(4), .CLK_DIV(3)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .abort(abort_b), .busy(busy_b),
        .done(done_b), .cfg_rd_addr(addr_b), .cfg_rd_data(rd_b), .serial_clock(sclk_b),
        .serial_data_out(sdo_b), .serial_load(load_b));

    gpio_cfg_loader #(.NUM_PADS(38), .CFG_BITS(13), .CLK_DIV(2)) dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_c), .abort(abort_c), .busy(busy_c),
        .done(done_c), .cfg_rd_addr(addr_c), .cfg_rd_data(rd_c), .serial_clock(sclk_c),
        .serial_data_out(sdo_c), .serial_load(load_c));

    // Register-file model: data valid one cycle after the address changes
    always @(posedge clk) begin
        rd_a <= mem_a[addr_a];
        rd_b <= mem_a[addr_b];
        rd_c <= mem_c[addr_c];
    end

    localparam logic [11:0] EXP_BITS = 12'b1010_0011_1111;
    localparam logic [63:0] EXP_LOAD = 64'h0000_0000_8000_0000;
    localparam logic [63:0] EXP_DONE = 64'h0000_0001_0000_0000;
    localparam logic [63:0] EXP_BUSY = 64'h0000_0000_FFFF_FFFE;

    // Drives one 40-cycle window on instance A; cycle 0 is the start cycle.
    // snap = {busy, done, addr[1:0], sclk, sdo, load} at cycle snap_at.
    task automatic run_a(input int restart_at, input int abort_at, input int reset_at,
                         input int snap_at, output logic [11:0] bits, output int nbits,
                         output logic [63:0] load_m, output logic [63:0] done_m,
                         output logic [63:0] busy_m, output logic [6:0] snap,
                         output int sdo_bad);
        logic sclk_prev, sdo_prev;
        bits = '0; nbits = 0; load_m = '0; done_m = '0; busy_m = '0; snap = '0; sdo_bad = 0;
        sclk_prev = 1'b0;
        sdo_prev = sdo_a;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sclk_a && !sclk_prev) begin
                bits = {bits[10:0], sdo_a};
                nbits++;
            end
            if (sdo_a !== sdo_prev && sclk_a) sdo_bad++;
            load_m[n] = load_a;
            done_m[n] = done_a;
            busy_m[n] = busy_a;
            if (n == snap_at) snap = {busy_a, done_a, addr_a, sclk_a, sdo_a, load_a};
            sclk_prev = sclk_a;
            sdo_prev = sdo_a;
            start_a = (n == 0) || (n == restart_at);
            abort_a = (n == abort_at);
            rst = (n == reset_at);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy_a, done_a, addr_a, sclk_a, sdo_a, load_a} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_a: got %b expected 0000000",
                     {busy_a, done_a, addr_a, sclk_a, sdo_a, load_a});
        end
        tests_run++;
        if ({busy_b, done_b, addr_b, sclk_b, sdo_b, load_b} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_b: got %b expected 0000000",
                     {busy_b, done_b, addr_b, sclk_b, sdo_b, load_b});
        end
        tests_run++;
        if ({busy_c, done_c, addr_c, sclk_c, sdo_c, load_c} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_c: got %b expected 0",
                     {busy_c, done_c, addr_c, sclk_c, sdo_c, load_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [11:0] bits; int nbits, bad; logic [63:0] lm, dm, bm; logic [6:0] snap;
        run_a(-1, -1, -1, 1, bits, nbits, lm, dm, bm, snap, bad);
        tests_run++;
        if (bits !== EXP_BITS || nbits != 12) begin
            tests_failed++;
            $display("FAIL basic_bits: got %b (%0d) expected %b (12)", bits, nbits, EXP_BITS);
        end
        tests_run++;
        if (lm !== EXP_LOAD) begin
            tests_failed++;
            $display("FAIL basic_load: got %h expected %h", lm, EXP_LOAD);
        end
        tests_run++;
        if (dm !== EXP_DONE) begin
            tests_failed++;
            $display("FAIL basic_done: got %h expected %h", dm, EXP_DONE);
        end
        tests_run++;
        if (bm !== EXP_BUSY) begin
            tests_failed++;
            $display("FAIL basic_busy: got %h expected %h", bm, EXP_BUSY);
        end
        tests_run++;
        if (snap !== 7'b1_0_10_0_0_0) begin
            tests_failed++;
            $display("FAIL basic_cycle1: got %b expected 1010000", snap);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL basic_sdo_while_high: got %0d expected 0", bad);
        end
    endtask

    task automatic test_clkdiv3();
        logic [127:0] lm, dm, exp_lm, exp_dm;
        logic [11:0] bits;
        logic sclk_prev, sdo_prev;
        int nbits, hi_len, hi_runs, hi_bad, since, stable_bad, sdo_bad;
        bits = '0; nbits = 0; hi_len = 0; hi_runs = 0; hi_bad = 0; since = 0;
        stable_bad = 0; sdo_bad = 0; lm = '0; dm = '0;
        exp_lm = '0; exp_dm = '0;
        for (int i = 79; i <= 81; i++) exp_lm[i] = 1'b1;
        exp_dm[82] = 1'b1;
        sclk_prev = 1'b0;
        sdo_prev = sdo_b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sdo_b !== sdo_prev) begin
                since = 0;
                if (sclk_b) sdo_bad++;
            end else begin
                since++;
            end
            if (sclk_b && !sclk_prev) begin
                bits = {bits[10:0], sdo_b};
                nbits++;
                if (since < 3) stable_bad++;
            end
            if (sclk_b) hi_len++;
            if (!sclk_b && sclk_prev) begin
                hi_runs++;
                if (hi_len != 3) hi_bad++;
                hi_len = 0;
            end
            lm[n] = load_b;
            dm[n] = done_b;
            if (load_b && sclk_b) sdo_bad++;
            sclk_prev = sclk_b;
            sdo_prev = sdo_b;
            start_b = (n == 0);
        end
        tests_run++;
        if (bits !== EXP_BITS || nbits != 12) begin
            tests_failed++;
            $display("FAIL div3_bits: got %b (%0d) expected %b (12)", bits, nbits, EXP_BITS);
        end
        tests_run++;
        if (hi_runs != 12 || hi_bad != 0) begin
            tests_failed++;
            $display("FAIL div3_high_len: got %0d runs, %0d wrong expected 12 runs, 0 wrong",
                     hi_runs, hi_bad);
        end
        tests_run++;
        if (sdo_bad != 0 || stable_bad != 0) begin
            tests_failed++;
            $display("FAIL div3_sdo_stable: got %0d/%0d expected 0/0", sdo_bad, stable_bad);
        end
        tests_run++;
        if (dm !== exp_dm) begin
            tests_failed++;
            $display("FAIL div3_done: got %h expected %h", dm, exp_dm);
        end
        tests_run++;
        if (lm !== exp_lm) begin
            tests_failed++;
            $display("FAIL div3_load: got %h expected %h", lm, exp_lm);
        end
    endtask

    task automatic test_start_while_busy();
        logic [11:0] bits; int nbits, bad; logic [63:0] lm, dm, bm; logic [6:0] snap;
        run_a(10, -1, -1, -1, bits, nbits, lm, dm, bm, snap, bad);
        tests_run++;
        if (bits !== EXP_BITS || nbits != 12) begin
            tests_failed++;
            $display("FAIL restart_bits: got %b (%0d) expected %b (12)", bits, nbits, EXP_BITS);
        end
        tests_run++;
        if (lm !== EXP_LOAD || dm !== EXP_DONE || bm !== EXP_BUSY) begin
            tests_failed++;
            $display("FAIL restart_timing: got load %h done %h busy %h expected %h %h %h",
                     lm, dm, bm, EXP_LOAD, EXP_DONE, EXP_BUSY);
        end
    endtask

    task automatic test_abort();
        logic [11:0] bits; int nbits, bad; logic [63:0] lm, dm, bm; logic [6:0] snap;
        // Cycle 15 is the first (low) cycle of pad 1's second bit
        run_a(-1, 15, -1, 16, bits, nbits, lm, dm, bm, snap, bad);
        tests_run++;
        if (snap[6] !== 1'b0 || snap[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_next_cycle: got busy %b sclk %b expected 0 0", snap[6], snap[2]);
        end
        tests_run++;
        if (lm !== '0 || dm !== '0) begin
            tests_failed++;
            $display("FAIL abort_no_load_done: got load %h done %h expected 0 0", lm, dm);
        end
        run_a(-1, -1, -1, -1, bits, nbits, lm, dm, bm, snap, bad);
        tests_run++;
        if (bits !== EXP_BITS || lm !== EXP_LOAD || dm !== EXP_DONE) begin
            tests_failed++;
            $display("FAIL abort_then_start: got bits %b load %h done %h expected %b %h %h",
                     bits, lm, dm, EXP_BITS, EXP_LOAD, EXP_DONE);
        end
    endtask

    task automatic test_start_with_abort();
        int seen_busy;
        seen_busy = 0;
        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (busy_a) seen_busy++;
            @(negedge clk);
        end
        tests_run++;
        if (seen_busy != 0) begin
            tests_failed++;
            $display("FAIL start_and_abort_idle: got %0d busy cycles expected 0", seen_busy);
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] bits; int nbits, bad; logic [63:0] lm, dm, bm; logic [6:0] snap;
        run_a(-1, -1, 5, 6, bits, nbits, lm, dm, bm, snap, bad);
        tests_run++;
        if (snap !== 7'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %b expected 0000000", snap);
        end
        tests_run++;
        if (lm !== '0 || dm !== '0) begin
            tests_failed++;
            $display("FAIL midreset_no_load_done: got load %h done %h expected 0 0", lm, dm);
        end
        run_a(-1, -1, -1, 1, bits, nbits, lm, dm, bm, snap, bad);
        tests_run++;
        if (bits !== EXP_BITS || nbits != 12 || lm !== EXP_LOAD || dm !== EXP_DONE ||
            bm !== EXP_BUSY || snap !== 7'b1010000) begin
            tests_failed++;
            $display("FAIL midreset_rerun: got bits %b load %h done %h busy %h snap %b",
                     bits, lm, dm, bm, snap);
        end
    endtask

    task automatic test_full_chain();
        logic [493:0] chain, latched;
        logic sclk_prev;
        int done_at, load_cycles, nbits;
        logic got_load;
        for (int p = 0; p < 64; p++) mem_c[p] = (p < 38) ? 13'($urandom_range(0, 8191)) : 13'h0;
        chain = '0; latched = '0; sclk_prev = 1'b0; done_at = -1; load_cycles = 0;
        nbits = 0; got_load = 1'b0;
        for (int n = 0; n < 2200 && done_at < 0; n++) begin
            @(negedge clk);
            if (sclk_c && !sclk_prev) begin
                chain = {chain[492:0], sdo_c};
                nbits++;
            end
            if (load_c) begin
                load_cycles++;
                if (!got_load) latched = chain;
                got_load = 1'b1;
            end
            if (done_c) done_at = n;
            sclk_prev = sclk_c;
            start_c = (n == 0);
        end
        tests_run++;
        if (done_at != 2055) begin
            tests_failed++;
            $display("FAIL chain_done_cycle: got %0d expected 2055", done_at);
        end
        tests_run++;
        if (load_cycles != 2 || nbits != 494) begin
            tests_failed++;
            $display("FAIL chain_load_bits: got %0d load cycles %0d bits expected 2 494",
                     load_cycles, nbits);
        end
        for (int p = 0; p < 38; p++) begin
            tests_run++;
            if (latched[p*13 +: 13] !== mem_c[p]) begin
                tests_failed++;
                $display("FAIL chain_pad%0d: got %h expected %h", p, latched[p*13 +: 13],
                         mem_c[p]);
            end
        end
    endtask

    initial begin
        mem_a[0] = 4'hF;
        mem_a[1] = 4'h3;
        mem_a[2] = 4'hA;
        mem_a[3] = 4'h0;
        for (int p = 0; p < 64; p++) mem_c[p] = '0;
        test_reset();
        test_basic();
        test_clkdiv3();
        test_start_while_busy();
        test_abort();
        test_start_with_abort();
        test_mid_reset();
        test_full_chain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
